// File: rtl/ppu_pkg.sv
// -----------------------------------------------------------------------------
// ppu_pkg
// Shared timing constants, palette types and small helper functions for the
// PPU pixel-output slice (ppu_palette_ram, ppu_pixel_out).
//
// Contents:
//   DOTS_PER_LINE / LINES_PER_FRAME  raster size in dots and scanlines
//   VIS_W / VIS_H                    visible picture size
//   VBL_SET_LINE / PRE_RENDER_LINE   vertical-blank set line, pre-render line
//   pixel_t / pal_idx_t / color_t    renderer pixel, palette index, NES colour
//   pal_fold()                       $10/$14/$18/$1C -> $00/$04/$08/$0C alias
//   pixel_to_idx()                   transparency rule for renderer pixels
//   is_visible()                     visible-region test on a raster position
//
// Optional feature used by the slice: PPU_GRAYSCALE_EN (see ppu_pixel_out).
// -----------------------------------------------------------------------------
package ppu_pkg;

    // Raster geometry. Typed 9 bits so they compare directly with dot/scanline.
    localparam logic [8:0] DOTS_PER_LINE   = 9'd341;
    localparam logic [8:0] LINES_PER_FRAME = 9'd262;
    localparam logic [8:0] VIS_W           = 9'd256;
    localparam logic [8:0] VIS_H           = 9'd240;
    localparam logic [8:0] VBL_SET_LINE    = 9'd241;
    localparam logic [8:0] PRE_RENDER_LINE = 9'd261;

    // {attr_hi, attr_lo, pat_hi, pat_lo} from the scanline renderer.
    typedef logic [3:0] pixel_t;
    // Palette RAM address ($3F00-$3F1F offset).
    typedef logic [4:0] pal_idx_t;
    // NES master-palette colour.
    typedef logic [5:0] color_t;

    // The sprite-palette backdrop slots ($10/$14/$18/$1C) are not separate
    // storage; they alias the background slots with bit 4 cleared. Entries
    // whose low two bits are non-zero ($11, $15, ...) are genuine and unfolded.
    function automatic pal_idx_t pal_fold(input pal_idx_t addr);
        pal_idx_t folded;
        folded = addr;
        if (addr[1:0] == 2'b00) begin
            folded[4] = 1'b0;
        end
        return folded;
    endfunction

    // A pattern value of 0 is transparent: every such pixel shows the
    // universal backdrop colour at entry 0, whatever its attribute bits say.
    function automatic pal_idx_t pixel_to_idx(input pixel_t px);
        pal_idx_t idx;
        if (px[1:0] == 2'b00) begin
            idx = '0;
        end else begin
            idx = {1'b0, px};
        end
        return idx;
    endfunction

    // Visible picture: scanlines 0..239, dots 1..256 (dot 0 is idle).
    function automatic logic is_visible(input logic [8:0] line,
                                        input logic [8:0] dot_pos);
        return (line < VIS_H) && (dot_pos != 9'd0) && (dot_pos <= VIS_W);
    endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// -----------------------------------------------------------------------------
// ppu_palette_ram
// 32 x 6-bit PPU palette store with the backdrop mirroring fold applied on
// every port.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high; clears only the read-port register
//   wr_en      write strobe; commits wr_data at the rising clk edge
//   wr_addr    write address (folded)
//   wr_data    write data
//   lk_idx     lookup index from the pixel pipeline (folded)
//   lk_color   lookup result, combinational from the array
//   rd_addr    CPU read address (folded)
//   rd_data    CPU read data, registered one cycle after rd_addr
//
// The lookup port reads the array combinationally, so a register capturing
// lk_color on the same edge that a write lands sees the pre-write contents:
// there is deliberately no write-to-lookup forwarding path.
// -----------------------------------------------------------------------------
module ppu_palette_ram
    import ppu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     wr_en,
    input  pal_idx_t wr_addr,
    input  color_t   wr_data,
    input  pal_idx_t lk_idx,
    output color_t   lk_color,
    input  pal_idx_t rd_addr,
    output color_t   rd_data
);

    color_t mem [32];

    // NOTE: the palette array has no reset branch. Its contents must survive
    // a PPU reset, and leaving it out of reset also lets it map onto plain
    // RAM cells instead of 192 resettable flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[pal_fold(wr_addr)] <= wr_data;
        end
    end

    assign lk_color = mem[pal_fold(lk_idx)];

    // NOTE: every clocked assignment uses <= so all registers sample the
    // pre-edge values; blocking assignments here would make results depend
    // on statement and process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[pal_fold(rd_addr)];
        end
    end

endmodule

// File: rtl/ppu_pixel_out.sv
// -----------------------------------------------------------------------------
// ppu_pixel_out
// PPU raster timing plus the palette-lookup output stage. Counts dots and
// scanlines, drives renderer control (y_idx, render_en), vertical blank and
// the frame-start pulse, and turns renderer pixels into master-palette colours
// one cycle after they are sampled.
//
// Ports:
//   clk          system clock, one PPU dot per rising edge
//   reset        asynchronous, active-high
//   pixel        {attr_hi, attr_lo, pat_hi, pat_lo} from the renderer
//   pal_we       palette write strobe (CPU side)
//   pal_addr     palette address, shared by CPU write and read
//   pal_wdata    palette write data
//   pal_rdata    palette read data, registered
//   y_idx        tile row to the renderer (scanline[7:3] while visible)
//   render_en    renderer enable (visible lines and pre-render line)
//   dot          current dot 0..340
//   scanline     current scanline 0..261
//   color        master-palette colour for the pixel sampled last cycle
//   color_valid  qualifies color
//   vblank       vertical-blank flag
//   frame_start  one-cycle pulse while at scanline 0, dot 0
//
// Configuration macro:
//   PPU_GRAYSCALE_EN  when defined, color is the lookup result ANDed with 6'h30
//                     (pal_rdata is never masked). When undefined no masking
//                     logic exists.
// -----------------------------------------------------------------------------
module ppu_pixel_out
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] pixel,
    input  logic       pal_we,
    input  logic [4:0] pal_addr,
    input  logic [5:0] pal_wdata,
    output logic [5:0] pal_rdata,
    output logic [7:0] y_idx,
    output logic       render_en,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic [5:0] color,
    output logic       color_valid,
    output logic       vblank,
    output logic       frame_start
);

    // Low for the single cycle after reset release: the counters hold at 0/0
    // for that edge so the first observed cycle is scanline 0, dot 0 with
    // frame_start raised, exactly like every later frame boundary.
    logic run;

    logic [8:0] nxt_dot;
    logic [8:0] nxt_line;
    pal_idx_t   lk_idx;
    color_t     lk_color;
    color_t     color_next;
    logic       in_visible;

    // ------------------------------------------------------------------
    // Palette store
    // ------------------------------------------------------------------
    ppu_palette_ram u_palette (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (pal_we),
        .wr_addr  (pal_addr),
        .wr_data  (pal_wdata),
        .lk_idx   (lk_idx),
        .lk_color (lk_color),
        .rd_addr  (pal_addr),
        .rd_data  (pal_rdata)
    );

    assign lk_idx = pixel_to_idx(pixel);

`ifdef PPU_GRAYSCALE_EN
    localparam color_t GRAY_MASK = 6'h30;
    assign color_next = lk_color & GRAY_MASK;
`else
    assign color_next = lk_color;
`endif

    // The pixel on the input belongs to the position currently shown on
    // dot/scanline; its colour is registered at the end of that cycle.
    assign in_visible = is_visible(scanline, dot);

    // ------------------------------------------------------------------
    // Next raster position
    // ------------------------------------------------------------------
    // NOTE: both outputs get a default before any branch, so every path
    // assigns them and no latch is inferred.
    always_comb begin
        nxt_dot  = dot;
        nxt_line = scanline;
        if (run) begin
            if (dot == DOTS_PER_LINE - 9'd1) begin
                nxt_dot = '0;
                if (scanline == LINES_PER_FRAME - 9'd1) begin
                    nxt_line = '0;
                end else begin
                    nxt_line = scanline + 9'd1;
                end
            end else begin
                nxt_dot = dot + 9'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters, position-derived flags and colour output
    // ------------------------------------------------------------------
    // Flags are computed from the next position so they are registered yet
    // line up with the dot/scanline values they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run         <= 1'b0;
            dot         <= '0;
            scanline    <= '0;
            frame_start <= 1'b0;
            render_en   <= 1'b0;
            y_idx       <= '0;
            vblank      <= 1'b0;
            color       <= '0;
            color_valid <= 1'b0;
        end else begin
            run         <= 1'b1;
            dot         <= nxt_dot;
            scanline    <= nxt_line;
            frame_start <= (nxt_dot == 9'd0) && (nxt_line == 9'd0);
            render_en   <= (nxt_line < VIS_H) || (nxt_line == PRE_RENDER_LINE);
            y_idx       <= (nxt_line < VIS_H) ? {3'b000, nxt_line[7:3]} : 8'd0;

            if ((nxt_line == VBL_SET_LINE) && (nxt_dot == 9'd1)) begin
                vblank <= 1'b1;
            end else if ((nxt_line == PRE_RENDER_LINE) && (nxt_dot == 9'd1)) begin
                vblank <= 1'b0;
            end

            // color holds its last value outside the picture; color_valid
            // is the only qualifier consumers should look at.
            color_valid <= in_visible;
            if (in_visible) begin
                color <= color_next;
            end
        end
    end

endmodule
